eeprom_word_fetcher: RTL and testbench
======================================

Name: eeprom_word_fetcher

Overview:
- Sequencer that sits directly upstream of the 32-bit EEPROM bank (13-bit address, four 8-bit banks, active-low CE/OE/WE).
- Drives the EEPROM control pins with programmable access wait-states and captures each 32-bit word.
- Buffers captured words in a 2-entry FIFO and hands them to the SHA-256 datapath, e.g. the 64 K-round constants or message words, over a valid/ready stream.
- Read-only: WE is never asserted.

Parameters:
- ADDR_W, 13, EEPROM address width (8192 words).
- DATA_W, 32, EEPROM word width.
- WAIT_CYCLES, 3, cycles OE is held low before IO is sampled (min 1).
- CNT_W, 7, width of burst length field (max 64 words used by SHA; 127 legal).
- FIFO_DEPTH, 2, output buffer entries (fixed 2 in this revision).

Ports:
- CLK, in, 1, single clock; all logic on rising edge.
- RST, in, 1, synchronous, active-high reset.
- START, in, 1, request pulse; sampled only when BUSY=0.
- BASE, in, ADDR_W, first word address, sampled with START.
- COUNT, in, CNT_W, number of words to fetch, sampled with START.
- A, out, ADDR_W [0:12], EEPROM address, registered.
- CE, out, 1, EEPROM chip enable, active low, registered.
- OE, out, 1, EEPROM output enable, active low, registered.
- WE, out, 1, EEPROM write enable; constant 1.
- IO, in, DATA_W [0:31], EEPROM read data; IO[0:7] is bank 1, the most-significant byte.
- DOUT, out, DATA_W, FIFO head word.
- DVALID, out, 1, DOUT holds a valid word.
- DREADY, in, 1, consumer accepts DOUT when DVALID&DREADY.
- BUSY, out, 1, burst in progress.
- DONE, out, 1, one-cycle pulse at burst end.

Behaviour:
- Reset (RST=1 at any edge, including mid-burst): A=0, CE=1, OE=1, WE=1, DVALID=0, DOUT=0, BUSY=0, DONE=0, FIFO emptied, FSM=IDLE. Any in-flight read is abandoned.
- FSM states: IDLE, SETUP, ACCESS, DRAIN, FINISH.
- IDLE:
  - START=1: latch BASE into addr reg and COUNT into remaining reg, set BUSY=1.
  - If COUNT=0, go to FINISH; otherwise go to SETUP.
- SETUP (1 cycle): A=addr, CE=0, OE=1. Entered only when FIFO occupancy < FIFO_DEPTH; otherwise stay with CE=1, OE=1 (stall) until a pop frees space.
- ACCESS (WAIT_CYCLES cycles): A held, CE=0, OE=0, wait counter counts down.
  - At the edge ending the last ACCESS cycle, IO is pushed into the FIFO, addr increments, and remaining decrements.
  - If remaining becomes nonzero, go to SETUP (CE stays 0 if space is available, else 1). Otherwise go to DRAIN with CE=1, OE=1.
- Per-word fetch cost is WAIT_CYCLES+1 cycles. With defaults: START at cycle 0 gives SETUP at 1, ACCESS at 2-4, DVALID=1 with word0 at cycle 5.
- DRAIN: wait until FIFO is empty (the last word has been accepted), then go to FINISH.
- FINISH (1 cycle): DONE=1, BUSY=0, then go to IDLE. A new START is accepted in the cycle after FINISH.
- Address arithmetic: addr = (addr+1) mod 2^ADDR_W, so 8191 wraps to 0.
- START while BUSY=1 is ignored and has no side effect.
- FIFO: DOUT and DVALID are driven directly from the head entry (no combinational path from IO).
  - A push and a pop in the same cycle are both honoured and occupancy is unchanged.
  - A pop when empty is impossible, since DVALID=0.
  - Word order is strictly by address.
- DREADY held low: the FIFO fills to 2, then the FSM stalls before SETUP with CE=1. No word is lost or duplicated.
- CE and OE never glitch low outside SETUP/ACCESS. OE=0 implies CE=0.

Decomposition:
- Shared package: ADDR_W, DATA_W, CNT_W defaults; FSM state enum (IDLE, SETUP, ACCESS, DRAIN, FINISH); SHA_K_BASE address constant.
- One sub-module: fetch_fifo2, a 2-entry synchronous FIFO with push/pop/full/empty and sync active-high reset, reused elsewhere in the datapath.

Test Plan:
- Bench EEPROM model returns IO = {19'b0, A} when CE=0 & OE=0, else 'z.
- Single word: BASE=0x0010, COUNT=1, DREADY=1 -> DVALID at cycle 5 with DOUT=0x00000010; DONE pulse at cycle 7; WE=1 throughout.
- Full K burst: BASE=0x0000, COUNT=64, DREADY=1 -> 64 words 0x0..0x3F in order, one every 4 cycles; CE low continuously; DONE exactly once.
- Backpressure: COUNT=5, DREADY=0 until cycle 30 -> FIFO holds 0,1; CE=1 from the stall on. After DREADY=1, words 2,3,4 follow and none are dropped.
- Wrap: BASE=0x1FFE, COUNT=4 -> DOUT sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Edge cases: COUNT=0 -> DONE at the next cycle, CE never low. START pulsed while BUSY -> ignored. RST asserted during ACCESS -> next cycle CE=1, OE=1, DVALID=0, BUSY=0, no DONE.

Source files
------------

// File: rtl/eeprom_word_fetcher_pkg.sv
// rtl/eeprom_word_fetcher_pkg.sv - shared widths, FSM states and constants for the EEPROM word fetcher
package eeprom_word_fetcher_pkg;

   // Default geometry of the EEPROM bank and the fetch engine
   localparam int ADDR_W_DEF      = 13;
   localparam int DATA_W_DEF      = 32;
   localparam int CNT_W_DEF       = 7;
   localparam int WAIT_CYCLES_DEF = 3;
   localparam int FIFO_DEPTH_DEF  = 2;

   // Word address of the 64 SHA-256 round constants inside the EEPROM
   localparam logic [ADDR_W_DEF-1:0] SHA_K_BASE = 13'h0000;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      DRAIN,
      FINISH
   } fetch_state_t;

endpackage

// File: rtl/eeprom_word_fetcher_fifo.sv
// rtl/eeprom_word_fetcher_fifo.sv - two-entry synchronous FIFO with registered head word
module fetch_fifo2
   import eeprom_word_fetcher_pkg::*;
#(
   parameter int WIDTH = DATA_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [1:0]       level
);

   logic [WIDTH-1:0] tail;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is dropped; a push into a full FIFO is only taken alongside a pop
   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign level = count;

   // Shift-style storage: head is always the oldest word so the consumer sees a plain register
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head <= push_data;
               end else begin
                  tail <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/eeprom_word_fetcher.sv
// rtl/eeprom_word_fetcher.sv - EEPROM burst reader feeding 32-bit words to the SHA-256 datapath
module eeprom_word_fetcher
   import eeprom_word_fetcher_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE,
   input  logic [CNT_W-1:0]  COUNT,
   output logic [0:ADDR_W-1] A,
   output logic              CE,
   output logic              OE,
   output logic              WE,
   input  logic [0:DATA_W-1] IO,
   output logic [DATA_W-1:0] DOUT,
   output logic              DVALID,
   input  logic              DREADY,
   output logic              BUSY,
   output logic              DONE
);

   localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

   fetch_state_t      state;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic [WAIT_W-1:0] wait_cnt;

   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        fifo_level;
   logic [2:0]        level_after_pop;
   logic              room_now;
   logic              room_after_push;

   // The device is only ever read
   assign WE = 1'b1;

   assign DVALID = !fifo_empty;
   assign pop    = DVALID && DREADY;

   // IO is captured on the edge that closes the final access cycle
   assign push = (state == ACCESS) && (wait_cnt == '0);

   // Space checks include a pop happening on the same edge so a stall releases without a lost cycle
   assign level_after_pop = {1'b0, fifo_level} - {2'b00, pop};
   assign room_now        = !fifo_full || pop;
   assign room_after_push = (level_after_pop + 3'd1) < DEPTH_L;

   fetch_fifo2 #(
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .push_data (IO),
      .pop       (pop),
      .head      (DOUT),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Burst sequencer: all EEPROM pins and status flags are registered here so none can glitch
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         wait_cnt  <= '0;
         A         <= '0;
         CE        <= 1'b1;
         OE        <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  addr      <= BASE;
                  remaining <= COUNT;
                  A         <= BASE;
                  if (COUNT == '0) begin
                     state <= FINISH;
                     DONE  <= 1'b1;
                     BUSY  <= 1'b0;
                  end else begin
                     // The FIFO is always empty in IDLE, so the first setup never stalls
                     state <= SETUP;
                     CE    <= 1'b0;
                     OE    <= 1'b1;
                     BUSY  <= 1'b1;
                  end
               end
            end
            SETUP: begin
               // CE high here means the FIFO was full and the setup cycle has not really started
               if (!CE) begin
                  state    <= ACCESS;
                  OE       <= 1'b0;
                  wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
               end else if (room_now) begin
                  CE <= 1'b0;
               end
            end
            ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else begin
                  addr      <= addr + 1'b1;
                  A         <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  OE        <= 1'b1;
                  if (remaining != CNT_W'(1)) begin
                     state <= SETUP;
                     CE    <= !room_after_push;
                  end else begin
                     state <= DRAIN;
                     CE    <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state <= FINISH;
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_word_fetcher.sv
// tb/tb_eeprom_word_fetcher.sv - scoreboard bench for the EEPROM word fetcher
module tb_eeprom_word_fetcher;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [12:0] BASE;
   logic [6:0]  COUNT;
   logic [0:12] A;
   logic        CE;
   logic        OE;
   logic        WE;
   wire  [0:31] IO;
   logic [31:0] DOUT;
   logic        DVALID;
   logic        DREADY;
   logic        BUSY;
   logic        DONE;

   int checks = 0;
   int errors = 0;
   int we_bad = 0;
   int oe_bad = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_word;

   logic        ce_h   [0:511];
   logic        oe_h   [0:511];
   logic        dv_h   [0:511];
   logic        busy_h [0:511];
   logic        done_h [0:511];
   logic [12:0] a_h    [0:511];
   logic [31:0] dout_h [0:511];

   int done_cyc;
   int ce_low;
   int done_cnt;

   // EEPROM model: each word holds its own address
   assign IO = (!CE && !OE) ? {19'b0, A} : 32'bz;

   eeprom_word_fetcher dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .BASE   (BASE),
      .COUNT  (COUNT),
      .A      (A),
      .CE     (CE),
      .OE     (OE),
      .WE     (WE),
      .IO     (IO),
      .DOUT   (DOUT),
      .DVALID (DVALID),
      .DREADY (DREADY),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a word is handed over, sampled just before the rising edge
   always @(negedge CLK) begin
      #4;
      if (WE !== 1'b1) we_bad++;
      if (OE === 1'b0 && CE !== 1'b0) oe_bad++;
      if (!RST && DVALID && DREADY) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word_order actual=%08h required=none", DOUT);
         end else begin
            exp_word = exp_q.pop_front();
            if (DOUT !== exp_word) begin
               errors++;
               $display("FAIL word_order actual=%08h required=%08h", DOUT, exp_word);
            end
         end
      end
   end

   // Issues START in cycle 0 and records pins each cycle until three cycles after DONE
   task automatic run_burst(input logic [12:0] base, input logic [6:0] cnt,
                            input int ready_cycle, input int spur_cycle);
      int c;
      int stop;
      c        = 0;
      stop     = 600;
      done_cyc = -1;
      ce_low   = 0;
      done_cnt = 0;
      BASE     = base;
      COUNT    = cnt;
      START    = 1'b1;
      DREADY   = (ready_cycle > 0) ? 1'b0 : 1'b1;
      while (c < stop) begin
         @(negedge CLK);
         c++;
         if (c == 1) START = 1'b0;
         if (c == ready_cycle) DREADY = 1'b1;
         if (c == spur_cycle) begin
            START = 1'b1;
            BASE  = 13'h0555;
            COUNT = 7'd7;
         end
         if (c == spur_cycle + 1) START = 1'b0;
         if (c < 512) begin
            ce_h[c]   = CE;
            oe_h[c]   = OE;
            dv_h[c]   = DVALID;
            busy_h[c] = BUSY;
            done_h[c] = DONE;
            a_h[c]    = A;
            dout_h[c] = DOUT;
         end
         if (!CE) ce_low++;
         if (DONE) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               stop     = c + 3;
            end
         end
      end
      DREADY = 1'b1;
   endtask

   initial begin
      RST    = 1'b1;
      START  = 1'b0;
      BASE   = '0;
      COUNT  = '0;
      DREADY = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_A", 32'(A), 32'h0);
      check("rst_CE", 32'(CE), 32'h1);
      check("rst_OE", 32'(OE), 32'h1);
      check("rst_WE", 32'(WE), 32'h1);
      check("rst_DVALID", 32'(DVALID), 32'h0);
      check("rst_DOUT", DOUT, 32'h0);
      check("rst_BUSY", 32'(BUSY), 32'h0);
      check("rst_DONE", 32'(DONE), 32'h0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // Single word
      exp_q.push_back(32'h0000_0010);
      run_burst(13'h0010, 7'd1, 0, -1);
      check("single_ce_c1", 32'(ce_h[1]), 32'h0);
      check("single_oe_c1", 32'(oe_h[1]), 32'h1);
      check("single_a_c1", 32'(a_h[1]), 32'h10);
      check("single_busy_c1", 32'(busy_h[1]), 32'h1);
      check("single_oe_c2", 32'(oe_h[2]), 32'h0);
      check("single_dv_c4", 32'(dv_h[4]), 32'h0);
      check("single_dv_c5", 32'(dv_h[5]), 32'h1);
      check("single_dout_c5", dout_h[5], 32'h0000_0010);
      check("single_ce_c5", 32'(ce_h[5]), 32'h1);
      check("single_done_c6", 32'(done_h[6]), 32'h0);
      check("single_done_cyc", 32'(done_cyc), 32'd7);
      check("single_busy_c7", 32'(busy_h[7]), 32'h0);
      check("single_done_cnt", 32'(done_cnt), 32'd1);
      check("single_left", 32'(exp_q.size()), 32'd0);

      // Full K-constant burst
      for (int i = 0; i < 64; i++) exp_q.push_back(32'(i));
      run_burst(13'h0000, 7'd64, 0, -1);
      check("k_done_cyc", 32'(done_cyc), 32'd259);
      check("k_done_cnt", 32'(done_cnt), 32'd1);
      check("k_ce_low", 32'(ce_low), 32'd256);
      check("k_a_c256", 32'(a_h[256]), 32'h3F);
      check("k_left", 32'(exp_q.size()), 32'd0);

      // Backpressure: consumer stalls until cycle 30
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(i));
      run_burst(13'h0000, 7'd5, 30, -1);
      check("bp_ce_c9", 32'(ce_h[9]), 32'h1);
      check("bp_ce_c29", 32'(ce_h[29]), 32'h1);
      check("bp_dv_c29", 32'(dv_h[29]), 32'h1);
      check("bp_dout_c29", dout_h[29], 32'h0);
      check("bp_ce_c31", 32'(ce_h[31]), 32'h0);
      check("bp_a_c31", 32'(a_h[31]), 32'h2);
      check("bp_ce_low", 32'(ce_low), 32'd20);
      check("bp_done_cyc", 32'(done_cyc), 32'd45);
      check("bp_left", 32'(exp_q.size()), 32'd0);

      // Address wrap
      exp_q.push_back(32'h0000_1FFE);
      exp_q.push_back(32'h0000_1FFF);
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0000_0001);
      run_burst(13'h1FFE, 7'd4, 0, -1);
      check("wrap_done_cyc", 32'(done_cyc), 32'd19);
      check("wrap_ce_low", 32'(ce_low), 32'd16);
      check("wrap_left", 32'(exp_q.size()), 32'd0);

      // Zero-length burst
      run_burst(13'h0123, 7'd0, 0, -1);
      check("zero_done_cyc", 32'(done_cyc), 32'd1);
      check("zero_ce_low", 32'(ce_low), 32'd0);
      check("zero_done_cnt", 32'(done_cnt), 32'd1);
      check("zero_busy_c1", 32'(busy_h[1]), 32'h0);

      // START while busy is ignored
      exp_q.push_back(32'h0000_0100);
      exp_q.push_back(32'h0000_0101);
      run_burst(13'h0100, 7'd2, 0, 3);
      check("spur_done_cyc", 32'(done_cyc), 32'd11);
      check("spur_done_cnt", 32'(done_cnt), 32'd1);
      check("spur_ce_low", 32'(ce_low), 32'd8);
      check("spur_a_c5", 32'(a_h[5]), 32'h101);
      check("spur_left", 32'(exp_q.size()), 32'd0);

      // Reset during ACCESS abandons the burst
      BASE  = 13'h0020;
      COUNT = 7'd3;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      check("rstmid_oe_c2", 32'(OE), 32'h0);
      RST = 1'b1;
      @(negedge CLK);
      check("rstmid_ce", 32'(CE), 32'h1);
      check("rstmid_oe", 32'(OE), 32'h1);
      check("rstmid_dvalid", 32'(DVALID), 32'h0);
      check("rstmid_busy", 32'(BUSY), 32'h0);
      check("rstmid_done", 32'(DONE), 32'h0);
      check("rstmid_a", 32'(A), 32'h0);
      RST = 1'b0;
      done_cnt = 0;
      ce_low   = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (DONE) done_cnt++;
         if (DVALID || !CE) ce_low++;
      end
      check("rstmid_no_done", 32'(done_cnt), 32'd0);
      check("rstmid_quiet", 32'(ce_low), 32'd0);

      repeat (2) @(negedge CLK);
      check("final_left", 32'(exp_q.size()), 32'd0);
      check("we_always_high", 32'(we_bad), 32'd0);
      check("oe_implies_ce", 32'(oe_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
